// File: rtl/up_down.sv
// up_down: free-running up/down counter with a registered output.
// The output is Gray-coded by default, so one output bit changes per step.
// Direction comes from `state` (1 = up, 0 = down), sampled on every rising clk.
// SATURATE selects between wrap-around and holding at the end values.
module up_down #(
  parameter int WIDTH    = 2,
  parameter int GRAY     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             state,
  output logic [WIDTH-1:0] toggle
);

  localparam logic [WIDTH-1:0] all_ones = '1;
  localparam logic [WIDTH-1:0] all_zero = '0;
  localparam logic [WIDTH-1:0] one      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Internal binary count. The output register is kept separately so that
  // `toggle` comes straight from a flop with no decode logic behind it.
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] toggle_nxt;
  logic             at_top;
  logic             at_bottom;
  logic             hold;

  assign at_top    = (cnt == all_ones);
  assign at_bottom = (cnt == all_zero);

  // Saturating mode freezes the count at the end it is pushing against.
  // When frozen, the encoded output is also unchanged, so there is no glitch.
  always_comb begin
    hold = 1'b0;
    if (SATURATE != 0) begin
      hold = state ? at_top : at_bottom;
    end
  end

  // Next binary count: unsigned WIDTH-bit arithmetic, so wrap is natural.
  always_comb begin
    cnt_nxt = cnt;
    if (!hold) begin
      if (state) begin
        cnt_nxt = cnt + one;
      end else begin
        cnt_nxt = cnt - one;
      end
    end
  end

  // Encode the next count so that the output flop updates on the same edge
  // as the counter, giving one edge of latency from the `state` sample.
  always_comb begin
    toggle_nxt = cnt_nxt;
    if (GRAY != 0) begin
      toggle_nxt = cnt_nxt ^ (cnt_nxt >> 1);
    end
  end

  // Counter and output register; reset clears both immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      toggle <= '0;
    end else begin
      cnt    <= cnt_nxt;
      toggle <= toggle_nxt;
    end
  end

endmodule

// File: tb/tb_up_down.sv
// Bench for up_down: three instances (2-bit Gray wrap, 2-bit binary
// saturate, 4-bit Gray wrap) share clk/rst/state and are compared against an
// integer reference model of the counting rules.
module tb_up_down;

  logic       clk;
  logic       rst;
  logic       state;
  logic [1:0] toggle_a;
  logic [1:0] toggle_b;
  logic [3:0] toggle_c;

  int checks;
  int errors;

  // Reference model: plain integer counts per instance.
  int cnt_a;
  int cnt_b;
  int cnt_c;
  logic [31:0] prev_a;
  logic [31:0] prev_c;

  up_down #(.WIDTH(2), .GRAY(1), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .state(state), .toggle(toggle_a)
  );
  up_down #(.WIDTH(2), .GRAY(0), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .state(state), .toggle(toggle_b)
  );
  up_down #(.WIDTH(4), .GRAY(1), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .state(state), .toggle(toggle_c)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int c, input int w, input bit up,
                                    input bit sat);
    int top;
    top = (1 << w) - 1;
    if (up) begin
      if (sat && c == top) return c;
      return (c + 1) % (top + 1);
    end else begin
      if (sat && c == 0) return c;
      return (c + top) % (top + 1);
    end
  endfunction

  function automatic logic [31:0] gray_of(input int c);
    logic [31:0] v;
    v = c;
    return v ^ (v >> 1);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "_a"}, 32'(toggle_a), gray_of(cnt_a));
    check_eq({tag, "_b"}, 32'(toggle_b), 32'(cnt_b));
    check_eq({tag, "_c"}, 32'(toggle_c), gray_of(cnt_c));
  endtask

  // One clock step: drive direction away from the edge, advance the model on
  // the edge, compare on the falling edge. Gray wrap instances must change
  // in exactly one bit on every step.
  task automatic step(input logic dir, input string tag);
    state = dir;
    @(posedge clk);
    cnt_a = model_next(cnt_a, 2, dir, 1'b0);
    cnt_b = model_next(cnt_b, 2, dir, 1'b1);
    cnt_c = model_next(cnt_c, 4, dir, 1'b0);
    @(negedge clk);
    check_all(tag);
    check_eq({tag, "_ham_a"}, $countones(prev_a ^ 32'(toggle_a)), 1);
    check_eq({tag, "_ham_c"}, $countones(prev_c ^ 32'(toggle_c)), 1);
    prev_a = 32'(toggle_a);
    prev_c = 32'(toggle_c);
  endtask

  task automatic do_reset(input logic dir);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_a", 32'(toggle_a), 0);
    check_eq("rst_async_b", 32'(toggle_b), 0);
    check_eq("rst_async_c", 32'(toggle_c), 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_hold_a", 32'(toggle_a), 0);
    check_eq("rst_hold_b", 32'(toggle_b), 0);
    check_eq("rst_hold_c", 32'(toggle_c), 0);
    state = dir;
    rst   = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    prev_a = 0;
    prev_c = 0;
  endtask

  logic [1:0] tab_down[4];
  logic [1:0] tab_up[10];
  logic [1:0] tab_sat_up[5];
  logic [1:0] tab_sat_dn[5];
  bit         seen_c[16];
  int         distinct;
  int         run_len;
  logic       run_dir;

  initial begin
    checks = 0;
    errors = 0;
    tab_down   = '{2'b10, 2'b11, 2'b01, 2'b00};
    tab_up     = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01,
                   2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    tab_sat_up = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    tab_sat_dn = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};

    rst   = 1'b1;
    state = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    prev_a = 0;
    prev_c = 0;
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Down-count across the wrap
    for (int i = 0; i < 4; i++) begin
      step(1'b0, "down");
      check_eq("down_tab", 32'(toggle_a), 32'(tab_down[i]));
    end

    // Up-count through two and a half revolutions
    for (int i = 0; i < 10; i++) begin
      step(1'b1, "up");
      check_eq("up_tab", 32'(toggle_a), 32'(tab_up[i]));
    end

    // Reversal: now at 11 (binary 2); down then up retraces immediately
    step(1'b0, "rev_dn");
    check_eq("rev_dn_tab", 32'(toggle_a), 32'h1);
    step(1'b1, "rev_up");
    check_eq("rev_up_tab", 32'(toggle_a), 32'h3);

    // Mid-count reset with toggle at 11, then a full 4-bit revolution
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) seen_c[i] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, "wrev");
      seen_c[toggle_c] = 1'b1;
      if (i < 5) check_eq("sat_up_tab", 32'(toggle_b), 32'(tab_sat_up[i]));
    end
    distinct = 0;
    for (int i = 0; i < 16; i++) distinct += int'(seen_c[i]);
    check_eq("wrev_distinct", distinct, 16);
    check_eq("wrev_home", 32'(toggle_c), 0);

    // Saturating instance back down to and held at zero
    for (int i = 0; i < 5; i++) begin
      step(1'b0, "sat_dn");
      check_eq("sat_dn_tab", 32'(toggle_b), 32'(tab_sat_dn[i]));
    end

    // Random direction runs; long runs push the saturating instance to its ends
    for (int r = 0; r < 60; r++) begin
      run_dir = 1'($urandom_range(0, 1));
      run_len = $urandom_range(1, 8);
      for (int i = 0; i < run_len; i++) begin
        if ($urandom_range(0, 5) == 0) step(~run_dir, "rand");
        else step(run_dir, "rand");
      end
    end

    // Reset again after random activity
    do_reset(1'b0);
    step(1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
